// File: rtl/ov7670_rgb444_capture.sv
// OV7670 QQVGA RGB444 capture: pairs camera bytes into 12-bit pixels, decimates 2x2, writes the frame buffer.
// Latency: 2-flop input sync + 1 clk to cap_we after the second byte of a kept pixel; address advances the clk after.
// No backpressure: the buffer must accept one write per cap_we pulse; clk must be >= 4x cam_pclk.
// Optional build macro OV7670_CAPTURE_TESTPAT_EN replaces camera pixel data with colour bars by stored column.
module ov7670_rgb444_capture #(
    parameter int c_cam_cols    = 160,
    parameter int c_cam_rows    = 120,
    parameter int c_img_cols    = c_cam_cols / 2,
    parameter int c_img_rows    = c_cam_rows / 2,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     cam_pclk,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [7:0]               cam_data,
    output logic                     cap_we,
    output logic [c_nb_img_pxls-1:0] cap_addr,
    output logic [c_nb_buf-1:0]      cap_pxl,
    output logic                     frame_done,
    output logic                     capturing
);

    localparam int nb_col = $clog2(c_cam_cols + 1);
    localparam int nb_row = $clog2(c_cam_rows + 1);
    localparam logic [nb_col-1:0]        col_max  = nb_col'(c_cam_cols);
    localparam logic [nb_row-1:0]        row_max  = nb_row'(c_cam_rows);
    localparam logic [c_nb_img_pxls-1:0] addr_max = c_nb_img_pxls'(c_img_pxls);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_sync  = 2'd1;
    localparam logic [1:0] st_frame = 2'd2;

    logic                     pclk_s1, pclk_s2, pclk_s3;
    logic                     vsync_s1, vsync_s2, vsync_s3;
    logic                     href_s1, href_s2, href_s3;
    logic [7:0]               data_s1, data_s2;
    logic                     pclk_re, vsync_rise, vsync_fall, href_fall;

    logic [1:0]               state;
    logic                     phase;
    logic [3:0]               red;
    logic [nb_col-1:0]        cam_col;
    logic [nb_row-1:0]        cam_row;
    logic [c_nb_img_pxls-1:0] addr;
    logic                     keep;
    logic [c_nb_buf-1:0]      pixel;

    // Bring every camera signal into the clk domain through matched 2-flop synchronizers, plus one edge-detect stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_s1  <= 1'b0;
            pclk_s2  <= 1'b0;
            pclk_s3  <= 1'b0;
            vsync_s1 <= 1'b0;
            vsync_s2 <= 1'b0;
            vsync_s3 <= 1'b0;
            href_s1  <= 1'b0;
            href_s2  <= 1'b0;
            href_s3  <= 1'b0;
            data_s1  <= 8'h00;
            data_s2  <= 8'h00;
        end else begin
            pclk_s1  <= cam_pclk;
            pclk_s2  <= pclk_s1;
            pclk_s3  <= pclk_s2;
            vsync_s1 <= cam_vsync;
            vsync_s2 <= vsync_s1;
            vsync_s3 <= vsync_s2;
            href_s1  <= cam_href;
            href_s2  <= href_s1;
            href_s3  <= href_s2;
            data_s1  <= cam_data;
            data_s2  <= data_s1;
        end
    end

    assign pclk_re    = pclk_s2 & ~pclk_s3;
    assign vsync_rise = vsync_s2 & ~vsync_s3;
    assign vsync_fall = ~vsync_s2 & vsync_s3;
    assign href_fall  = ~href_s2 & href_s3;

    // Keep only even columns of even lines inside the nominal frame, and never past the end of the buffer.
    assign keep = ~cam_col[0] & ~cam_row[0] & (cam_col < col_max) & (cam_row < row_max) & (addr < addr_max);

`ifdef OV7670_CAPTURE_TESTPAT_EN
    logic [6:0] img_col;
    assign img_col = 7'(cam_col >> 1);
    assign pixel   = c_nb_buf'({{4{img_col[6]}}, {4{img_col[5]}}, {4{img_col[4]}}});
`else
    assign pixel   = c_nb_buf'({red, data_s2});
`endif

    assign cap_addr  = addr;
    assign capturing = (state == st_frame);

    // Frame FSM, byte pairing, decimation and buffer write generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= st_idle;
            phase      <= 1'b0;
            red        <= 4'h0;
            cam_col    <= '0;
            cam_row    <= '0;
            addr       <= '0;
            cap_we     <= 1'b0;
            cap_pxl    <= '0;
            frame_done <= 1'b0;
        end else begin
            cap_we     <= 1'b0;
            frame_done <= 1'b0;
            // The write issued last cycle has been taken; move on to the next buffer slot.
            if (cap_we) begin
                addr <= addr + 1'b1;
            end
            case (state)
                st_idle: begin
                    // Wait for vertical blanking so a frame already in flight at reset is skipped.
                    if (vsync_s2) begin
                        state <= st_sync;
                    end
                end
                st_sync: begin
                    if (vsync_fall) begin
                        cam_col <= '0;
                        cam_row <= '0;
                        addr    <= '0;
                        phase   <= 1'b0;
                        state   <= st_frame;
                    end
                end
                st_frame: begin
                    if (vsync_rise) begin
                        frame_done <= (addr == addr_max);
                        state      <= st_sync;
                    end else if (href_fall) begin
                        // A dangling first byte from an odd-length line is dropped here.
                        phase   <= 1'b0;
                        cam_col <= '0;
                        if (cam_row != row_max) begin
                            cam_row <= cam_row + 1'b1;
                        end
                    end else if (pclk_re && href_s2) begin
                        if (!phase) begin
                            red   <= data_s2[3:0];
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (cam_col != col_max) begin
                                cam_col <= cam_col + 1'b1;
                            end
                            if (keep) begin
                                cap_we  <= 1'b1;
                                cap_pxl <= pixel;
                            end
                        end
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// Bench for ov7670_rgb444_capture on a reduced 16x12 camera frame (8x6 stored) to keep runtime short.
// Expected writes are queued as camera bytes are driven and compared as cap_we pulses appear.
// Frame-level checks cover write counts and frame_done after each vsync rise.
module tb_ov7670_rgb444_capture;

    localparam int COLS     = 16;
    localparam int ROWS     = 12;
    localparam int IMG_COLS = COLS / 2;
    localparam int IMG_PXLS = (COLS / 2) * (ROWS / 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        cap_we;
    logic [12:0] cap_addr;
    logic [11:0] cap_pxl;
    logic        frame_done;
    logic        capturing;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_fd   = 0;
    int exp_fd = 0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    ov7670_rgb444_capture #(
        .c_cam_cols(COLS),
        .c_cam_rows(ROWS)
    ) dut (
        .rst       (rst),
        .clk       (clk),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .cap_we    (cap_we),
        .cap_addr  (cap_addr),
        .cap_pxl   (cap_pxl),
        .frame_done(frame_done),
        .capturing (capturing)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (frame_done === 1'b1) n_fd++;
        if (cap_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(cap_we), 32'd0);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(cap_addr), 32'(e[24:12]));
                chk("wr_pxl", 32'(cap_pxl), 32'(e[11:0]));
            end
        end
    end

    // One camera pclk period: signals change at the falling edge, sampled at the rising edge.
    task automatic pk(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
        cam_pclk  = 1'b0;
        #20;
        cam_pclk  = 1'b1;
        #20;
    endtask

    task automatic vgap(input int n);
        repeat (n) pk(1'b1, 1'b0, 8'h00);
    endtask

    // mode 0: constant 0x0A,0xBC; mode 1: ramp by pixel index; mode 2: random bytes.
    task automatic frame(input int nlines, input int nbytes, input int mode, input bit store, input int rst_line);
        int m_addr;
        int w0;
        int exp_w;
        logic [7:0] b0;
        logic [7:0] d;
        logic [7:0] cv;
        m_addr = 0;
        w0     = n_wr;
        exp_w  = 0;
        b0     = 8'h00;
        for (int r = 0; r < nlines; r++) begin
            repeat (4) pk(1'b0, 1'b0, 8'h00);
            for (int b = 0; b < nbytes; b++) begin
                int c;
                c  = b / 2;
                cv = 8'(c);
                if (r == rst_line && b == nbytes / 2) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_mid_we", 32'(cap_we), 32'd0);
                    chk("rst_mid_addr", 32'(cap_addr), 32'd0);
                    chk("rst_mid_pxl", 32'(cap_pxl), 32'd0);
                    chk("rst_mid_capturing", 32'(capturing), 32'd0);
                    #19;
                    exp_q.delete();
                    pk(1'b0, 1'b1, 8'h55);
                    rst   = 1'b0;
                    store = 1'b0;
                    w0    = n_wr;
                    exp_w = 0;
                end
                case (mode)
                    0:       d = (b % 2 == 0) ? 8'h0A : 8'hBC;
                    1:       d = (b % 2 == 0) ? {cv[3:0], 4'h0} : cv;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                if (b % 2 == 0) begin
                    b0 = d;
                end else if (store && r < ROWS && r % 2 == 0 && c < COLS && c % 2 == 0 && m_addr < IMG_PXLS) begin
`ifdef OV7670_CAPTURE_TESTPAT_EN
                    logic [6:0] sc;
                    sc = 7'(m_addr % IMG_COLS);
                    exp_q.push_back({13'(m_addr), {4{sc[6]}}, {4{sc[5]}}, {4{sc[4]}}});
`else
                    exp_q.push_back({13'(m_addr), b0[3:0], d});
`endif
                    m_addr++;
                    exp_w++;
                end
                pk(1'b0, 1'b1, d);
            end
            pk(1'b0, 1'b0, 8'h00);
        end
        repeat (4) pk(1'b0, 1'b0, 8'h00);
        vgap(10);
        if (store && m_addr == IMG_PXLS) exp_fd++;
        chk("frame_writes", 32'(n_wr - w0), 32'(exp_w));
        chk("frame_done_count", 32'(n_fd), 32'(exp_fd));
    endtask

    initial begin
        #40;
        chk("reset_we", 32'(cap_we), 32'd0);
        chk("reset_addr", 32'(cap_addr), 32'd0);
        chk("reset_pxl", 32'(cap_pxl), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_capturing", 32'(capturing), 32'd0);
        rst = 1'b0;
        vgap(10);
        // Full frame of constant pixels, then a ramp frame.
        frame(ROWS, 2 * COLS, 0, 1'b1, -1);
        frame(ROWS, 2 * COLS, 1, 1'b1, -1);
        // Reset while vsync is low: the in-flight frame must not be stored.
        repeat (2) pk(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        pk(1'b0, 1'b0, 8'h00);
        chk("reset2_capturing", 32'(capturing), 32'd0);
        rst = 1'b0;
        frame(ROWS / 2, 2 * COLS, 2, 1'b0, -1);
        frame(ROWS, 2 * COLS, 2, 1'b1, -1);
        // Short frame (partial, no frame_done), then a full frame restarting at address 0.
        frame(ROWS / 2, 2 * COLS, 2, 1'b1, -1);
        frame(ROWS, 2 * COLS, 2, 1'b1, -1);
        // Odd-length, over-long lines and extra rows.
        frame(ROWS + 2, 2 * COLS + 1, 2, 1'b1, -1);
        frame(ROWS, 2 * COLS, 2, 1'b1, -1);
        // Reset in the middle of a line, then a clean frame.
        frame(ROWS, 2 * COLS, 2, 1'b1, ROWS / 2);
        frame(ROWS, 2 * COLS, 2, 1'b1, -1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_rgb444_capture.md
Name: ov7670_rgb444_capture

Overview:
- Writer side of the original-image frame buffer. Receives the OV7670 parallel stream in QQVGA RGB444 format (160x120, two bytes per pixel).
- Decimates the stream by 2 in both axes and writes 80x60 pixels of 12 bits into the buffer. The colour processing stage later reads this buffer.
- All logic runs in the fpga clk domain. Camera signals are synchronized internally, and cam_pclk is edge-detected, not used as a clock.

Parameters:
- c_cam_cols, 160, camera pixels per line.
- c_cam_rows, 120, camera lines per frame.
- c_img_cols, 80, stored columns (c_cam_cols/2).
- c_img_rows, 60, stored rows (c_cam_rows/2).
- c_img_pxls, c_img_cols*c_img_rows, stored pixels per frame (4800).
- c_nb_img_pxls, 13, address width.
- c_nb_buf, 12, stored pixel width (RRRRGGGGBBBB).

Ports:
- rst  in  1  reset, asynchronous, active-high.
- clk  in  1  fpga clock. Must be at least 4x cam_pclk.
- cam_pclk  in  1  camera pixel clock, sampled as data.
- cam_vsync  in  1  camera vsync, high between frames.
- cam_href  in  1  camera line valid, high during active bytes.
- cam_data  in  8  camera byte.
- cap_we  out  1  buffer write enable, one-clk pulse.
- cap_addr  out  c_nb_img_pxls  buffer write address.
- cap_pxl  out  c_nb_buf  pixel to write.
- frame_done  out  1  one-clk pulse when a complete frame has been written.
- capturing  out  1  high while in state FRAME.

Behaviour:
- Synchronization:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through an identical 2-flop synchronizer.
  - A third flop on the synced pclk gives rising-edge detect pclk_re.
  - All camera sampling uses the synced values, and only in cycles where pclk_re=1.
- Reset values: cap_we=0, cap_addr=0, cap_pxl=0, frame_done=0, capturing=0, state=IDLE, all counters 0, byte phase 0.
- FSM:
  - IDLE: go to SYNC when synced vsync=1. Guarantees that a partial frame after reset is never stored.
  - SYNC: on synced vsync falling edge, clear col/row/addr counters and phase, then go to FRAME.
  - FRAME: capture. On synced vsync rising edge, pulse frame_done for 1 clk only if addr reached c_img_pxls, then go to SYNC.
- Byte pairing, in FRAME, on pclk_re with href=1:
  - phase 0: latch red = data[3:0]; phase becomes 1.
  - phase 1: form pixel {red, data[7:4], data[3:0]}; phase becomes 0; cam_col increments.
  - On href falling edge: phase=0, cam_col=0, cam_row increments.
- Decimation: write only when cam_col[0]=0, cam_row[0]=0, cam_col<c_cam_cols and cam_row<c_cam_rows, i.e. even columns of even lines.
- Write timing:
  - cap_we=1 in the clk cycle after the phase-1 sample, with cap_pxl and cap_addr valid in that same cycle.
  - Next cycle: cap_we=0 and addr increments.
  - cap_pxl holds its last value between writes.
- Overflow: when addr=c_img_pxls, further writes are suppressed (cap_we stays 0). addr saturates and never wraps within a frame.
- Extra bytes:
  - An odd byte count per line leaves a dangling phase 1, which is cleared at href fall.
  - Lines longer than c_cam_cols and rows beyond c_cam_rows are ignored.
- Short frame: vsync rising before 4800 writes returns to SYNC without frame_done. The buffer keeps partial data.
- Mid-operation reset: everything returns to reset values immediately, including a cap_we in progress. Capture resumes only from IDLE.

Optional Feature:
- Macro: OV7670_CAPTURE_TESTPAT_EN.
- Defined: cam_data is ignored.
  - cap_pxl = colour bar from stored column: cap_addr column bits [6:4] selects one of 8 colours, where bit2→R=F, bit1→G=F, bit0→B=F, else 0.
  - The full timing, FSM, decimation and frame_done behaviour still follow the camera sync signals.
- Undefined: camera data is stored as described above.

Test Plan:
- Reset, then vsync high 10 pclk, low, then 120 lines x 320 bytes with pixel (c,r) bytes 0x0A, 0xBC → exactly 4800 cap_we pulses. Addresses run 0..4799 with each address appearing once, cap_pxl=0xABC, and one frame_done at the next vsync rise.
- Line 0 with pixel n bytes {0x0n[3:0], n} → writes only for n=0,2,4…; first three writes are addr 0,1,2 with pxl 0x000, 0x002, 0x004. Odd lines produce no writes.
- Stream begins mid-frame with vsync low at reset release → no writes until a full vsync high-then-low cycle has been seen.
- Frame of only 50 lines → 2000 writes (25 stored rows x 80) and no frame_done. The next full frame restarts at addr 0.
- Lines of 321 bytes and 130 lines → still exactly 4800 writes, last addr 4799, and no byte misalignment on the following line.
- Assert rst during line 30 → outputs 0 within the same cycle. After release, the FSM waits in IDLE/SYNC, then the next full frame produces 4800 writes.
